mio_bus_responder: RTL and testbench



---
 rtl/mio_bus_responder.sv | 120 ++++++++++++
 tb/tb_mio_bus_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU data-bus responder: word RAM plus LED/switch/cycle-counter IO with wait states
module mio_bus_responder #(
    parameter int RAM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [31:0] address,
    input  logic [31:0] data_from_cpu,
    output logic [31:0] data_to_cpu,
    output logic        mio_ready,
    input  logic [15:0] switches_in,
    output logic [15:0] led_out
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q;
    logic           gap_q;
    logic           we_q;
    logic           io_q;
    logic [1:0]     sel_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [31:0]    dout_q;
    logic [31:0]    cyc_q;
    logic [15:0]    led_q;
    logic [WW-1:0]  wait_q;
    logic [31:0]    mem_q [RAM_WORDS];

    logic [31:0]    rdata;
    logic           resp;
    logic           cyc_wr;
    logic           unused_addr;

    // Only the decoded address fields are latched; the rest of the bus is don't-care.
    assign unused_addr = ^address;

    assign resp   = (state_q == S_RESP);
    assign cyc_wr = resp && we_q && io_q && (sel_q == 2'd2);

    always_comb begin
        rdata = 32'h0;
        if (io_q) begin
            case (sel_q)
                2'd0:    rdata = {16'h0, led_q};
                2'd1:    rdata = {16'h0, switches_in};
                2'd2:    rdata = cyc_q;
                default: rdata = 32'h0;
            endcase
        end else begin
            rdata = mem_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            sel_q   <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            cyc_q   <= 32'h0;
            led_q   <= 16'h0;
            wait_q  <= '0;
        end else begin
            cyc_q <= cyc_wr ? wdata_q : cyc_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    gap_q <= 1'b0;
                    // The cycle right after a response never captures, forcing a gap.
                    if (cpu_mio && !gap_q) begin
                        we_q    <= mem_w;
                        io_q    <= (address[31:28] == 4'hF);
                        sel_q   <= address[3:2];
                        idx_q   <= address[AW+1:2];
                        wdata_q <= data_from_cpu;
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= S_RESP;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    gap_q   <= 1'b1;
                    if (we_q) begin
                        if (io_q && (sel_q == 2'd0)) led_q <= wdata_q[15:0];
                    end else begin
                        dout_q <= rdata;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resp && we_q && !io_q) mem_q[idx_q] <= wdata_q;
    end

    assign mio_ready   = resp;
    assign data_to_cpu = (resp && !we_q) ? rdata : dout_q;
    assign led_out     = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - directed bench for mio_bus_responder with WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw  = 16'h0;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = 32'h0, wd1 = 32'h0, rd1;
    logic        rdy1;
    logic [15:0] led1;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'h0, wd0 = 32'h0, rd0;
    logic        rdy0;
    logic [15:0] led0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mio_bus_responder #(.RAM_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_mio(req1), .mem_w(we1), .address(addr1),
        .data_from_cpu(wd1), .data_to_cpu(rd1), .mio_ready(rdy1),
        .switches_in(sw), .led_out(led1)
    );

    mio_bus_responder #(.RAM_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .cpu_mio(req0), .mem_w(we0), .address(addr0),
        .data_from_cpu(wd0), .data_to_cpu(rd0), .mio_ready(rdy0),
        .switches_in(sw), .led_out(led0)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One handshake: drive, wait for ready, check latency/data, drop request, check pulse and LEDs.
    task automatic xact(input bit d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [15:0] swv, input logic [31:0] exp_rd, input logic [15:0] exp_led,
                        input int exp_lat);
        int cnt;
        bit seen;
        @(posedge clk); #1;
        sw = swv;
        if (d) begin req1 = 1'b1; we1 = we; addr1 = addr; wd1 = wdata; end
        else   begin req0 = 1'b1; we0 = we; addr0 = addr; wd0 = wdata; end
        cnt = 0;
        seen = 1'b0;
        while (cnt < 20 && !seen) begin
            @(negedge clk);
            if ((d ? rdy1 : rdy0) === 1'b1) seen = 1'b1;
            else cnt++;
        end
        check("ready_seen", {31'h0, seen}, 32'd1);
        check("latency", cnt, exp_lat);
        check("data_to_cpu", d ? rd1 : rd0, exp_rd);
        @(posedge clk); #1;
        if (d) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'h0, d ? rdy1 : rdy0}, 32'd0);
        check("led_out", {16'h0, d ? led1 : led0}, {16'h0, exp_led});
        check("data_held", d ? rd1 : rd0, exp_rd);
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0,    32'h0000_0000, 16'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0,    32'hDEAD_BEEF, 16'h0};
        vecs[2]  = '{1'b0, 32'h0000_0410, 32'h0,         16'h0,    32'hDEAD_BEEF, 16'h0};
        vecs[3]  = '{1'b1, 32'hF000_0000, 32'h1234_ABCD, 16'h0,    32'hDEAD_BEEF, 16'hABCD};
        vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         16'h5A5A, 32'h0000_5A5A, 16'hABCD};
        vecs[5]  = '{1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 16'h0,    32'h0000_5A5A, 16'hABCD};
        vecs[6]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h0,    32'h0000_ABCD, 16'hABCD};
        vecs[7]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 16'h0,    32'h0000_ABCD, 16'hABCD};
        vecs[8]  = '{1'b0, 32'h0000_0423, 32'h0,         16'h0,    32'hCAFE_F00D, 16'hABCD};
        vecs[9]  = '{1'b0, 32'hE000_0010, 32'h0,         16'h0,    32'hDEAD_BEEF, 16'hABCD};
        vecs[10] = '{1'b0, 32'hF000_000C, 32'h0,         16'h0,    32'h0000_0000, 16'hABCD};
        vecs[11] = '{1'b1, 32'hF000_000C, 32'h0000_0055, 16'h0,    32'h0000_0000, 16'hABCD};
        vecs[12] = '{1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 16'h0,    32'h0000_0000, 16'hABCD};
        // Counter holds FFFFFFFE in the cycle after the store's response, so this
        // load's response two cycles of gap/wait later sees 1, and the next one 5.
        vecs[13] = '{1'b0, 32'hF000_0008, 32'h0,         16'h0,    32'h0000_0001, 16'hABCD};
        vecs[14] = '{1'b0, 32'hF000_0008, 32'h0,         16'h0,    32'h0000_0005, 16'hABCD};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready1", {31'h0, rdy1}, 32'd0);
        check("rst_data1", rd1, 32'd0);
        check("rst_led1", {16'h0, led1}, 32'd0);
        check("rst_ready0", {31'h0, rdy0}, 32'd0);
        #1 rst = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdy1 === 1'b1 || rdy0 === 1'b1) pulses++;
        end
        check("idle_no_ready", pulses, 0);

        for (int i = 0; i < 15; i++)
            xact(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw,
                 vecs[i].exp_rd, vecs[i].exp_led, 2);

        // Request dropped during WAIT still completes exactly once.
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0010;
        @(posedge clk); #1;
        req1 = 1'b0; addr1 = 32'h0000_0020;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy1 === 1'b1) begin
                pulses++;
                check("drop_data", rd1, 32'hDEAD_BEEF);
            end
        end
        check("drop_pulses", pulses, 1);

        // Zero wait states: continuous request gives ready, gap, capture, ready...
        xact(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0077, 16'h0, 32'h0, 16'h0, 1);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("hold_ready", {31'h0, rdy0}, (i % 3 == 1) ? 32'd1 : 32'd0);
            if (i % 3 == 1) check("hold_data", rd0, 32'h0000_0077);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during WAIT of a store: aborted, no ready, RAM untouched.
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0010; wd1 = 32'h1111_1111;
        @(posedge clk); #1;
        rst = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'h0, rdy1}, 32'd0);
        check("abort_led", {16'h0, led1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdy1 === 1'b1) pulses++;
        end
        check("abort_no_ready", pulses, 0);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, 16'h0, 32'hDEAD_BEEF, 16'h0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
